// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store split unit.
package lsu_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned IDXW = 61;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC0,
      S_ACC1,
      S_DONE
   } state_e;

   // Access size in bytes from funct3[1:0].
   function automatic logic [3:0] size_bytes(input logic [1:0] sz);
      return 4'(4'd1 << sz);
   endfunction

   function automatic logic funct3_illegal(input logic write, input logic [2:0] f3);
      if (write) return !(f3 inside {F3_B, F3_H, F3_W, F3_D});
      return !(f3 inside {F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU});
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment over a 16-byte window: store masks/data and load extraction.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      offset,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata_lo,
   input  logic [XLEN-1:0] rdata_hi,
   output logic [XLEN-1:0] mask_lo,
   output logic [XLEN-1:0] mask_hi,
   output logic [XLEN-1:0] wdata_lo,
   output logic [XLEN-1:0] wdata_hi,
   output logic [XLEN-1:0] load_data
);

   logic [15:0]       byte_mask;
   logic [2*XLEN-1:0] bit_mask;
   logic [2*XLEN-1:0] wdata_win;
   logic [5:0]        shamt;
   logic [XLEN-1:0]   win;
   logic              sext;

   always_comb begin
      shamt     = {offset, 3'b000};
      byte_mask = ((16'd1 << size_bytes(funct3[1:0])) - 16'd1) << offset;
      for (int i = 0; i < 16; i++) begin
         bit_mask[8*i +: 8] = {8{byte_mask[i]}};
      end
      wdata_win = {{XLEN{1'b0}}, wdata} << shamt;
      // Loaded bytes are right-aligned out of the two captured doublewords.
      win       = XLEN'({rdata_hi, rdata_lo} >> shamt);
      sext      = !funct3[2];
      case (funct3[1:0])
         2'd0:    load_data = {{56{sext & win[7]}},  win[7:0]};
         2'd1:    load_data = {{48{sext & win[15]}}, win[15:0]};
         2'd2:    load_data = {{32{sext & win[31]}}, win[31:0]};
         default: load_data = win;
      endcase
      mask_lo  = bit_mask[XLEN-1:0];
      mask_hi  = bit_mask[2*XLEN-1:XLEN];
      wdata_lo = wdata_win[XLEN-1:0];
      wdata_hi = wdata_win[2*XLEN-1:XLEN];
   end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit that splits doubleword-crossing accesses into two memory cycles.
module lsu_split
   import lsu_pkg::*;
#(
   parameter bit MISALIGNED_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_err,
   output logic [XLEN-1:0] mem_address,
   output logic            mem_write,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata
);

   state_e          state_q, state_d;
   logic            write_q, write_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [XLEN-1:0] rd0_q, rd0_d;
   logic [XLEN-1:0] rd1_q, rd1_d;

   logic [3:0]      size;
   logic            split, misaligned, err;
   logic [IDXW-1:0] idx0, idx1;
   logic [XLEN-1:0] mask_lo, mask_hi, wdata_lo, wdata_hi, load_data;

   lsu_align u_align (
      .offset    (addr_q[2:0]),
      .funct3    (funct3_q),
      .wdata     (wdata_q),
      .rdata_lo  (rd0_q),
      .rdata_hi  (rd1_q),
      .mask_lo   (mask_lo),
      .mask_hi   (mask_hi),
      .wdata_lo  (wdata_lo),
      .wdata_hi  (wdata_hi),
      .load_data (load_data)
   );

   // Request classification from the latched fields.
   always_comb begin
      size       = size_bytes(funct3_q[1:0]);
      split      = ({1'b0, addr_q[2:0]} + size) > 4'd8;
      misaligned = (addr_q[2:0] & 3'(size - 4'd1)) != 3'd0;
      err        = funct3_illegal(write_q, funct3_q) || (!MISALIGNED_EN && misaligned);
      idx0       = addr_q[XLEN-1:3];
      idx1       = idx0 + IDXW'(1);
   end

   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd0_d       = rd0_q;
      rd1_d       = rd1_q;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      resp_err    = 1'b0;
      resp_rdata  = '0;
      mem_address = '0;
      mem_write   = 1'b0;
      mem_wdata   = '0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               write_d  = req_write;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rd0_d    = '0;
               rd1_d    = '0;
               state_d  = S_ACC0;
            end
         end
         S_ACC0: begin
            mem_address = {3'b000, idx0};
            if (!err) begin
               if (write_q) begin
                  mem_write = 1'b1;
                  mem_wdata = (mem_rdata & ~mask_lo) | (wdata_lo & mask_lo);
               end else begin
                  rd0_d = mem_rdata;
               end
            end
            state_d = (!err && split) ? S_ACC1 : S_DONE;
         end
         S_ACC1: begin
            mem_address = {3'b000, idx1};
            if (write_q) begin
               mem_write = 1'b1;
               mem_wdata = (mem_rdata & ~mask_hi) | (wdata_hi & mask_hi);
            end else begin
               rd1_d = mem_rdata;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            resp_valid = 1'b1;
            resp_err   = err;
            if (!err && !write_q) resp_rdata = load_data;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Reset suppresses handshakes and any memory or response side effects.
      if (reset) begin
         req_ready  = 1'b0;
         resp_valid = 1'b0;
         resp_err   = 1'b0;
         resp_rdata = '0;
         mem_write  = 1'b0;
         mem_wdata  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= '0;
         rd0_q    <= '0;
         rd1_q    <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rd0_q    <= rd0_d;
         rd1_q    <= rd1_d;
      end
   end

endmodule

// File: tb/tb_lsu_split.sv
// Randomized and directed bench for lsu_split against a byte-level memory model.
module tb_lsu_split;

   typedef struct {
      logic        err;
      logic [63:0] rd;
      int          lat;
      int          hs;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [63:0] resp_rdata, mem_address, mem_wdata, mem_rdata;
   logic        mem_write;

   logic        b_req_valid, b_req_ready, b_req_write;
   logic [2:0]  b_req_funct3;
   logic [63:0] b_req_addr, b_req_wdata;
   logic        b_resp_valid, b_resp_err, b_mem_write;
   logic [63:0] b_resp_rdata, b_mem_address, b_mem_wdata;
   logic [63:0] b_mem_rdata;

   logic [63:0] mem [64];
   logic [7:0]  ref_mem [512];
   exp_t        q[$];
   int          cyc = 0, wr_cnt = 0, exp_wr = 0, b_wr = 0, resp_cnt = 0;
   int          pass = 0, total = 0;
   logic [63:0] last_rd;
   logic        last_err;
   int          last_lat;

   always #5 clk = ~clk;

   lsu_split dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_address(mem_address), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   lsu_split #(.MISALIGNED_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
      .req_write(b_req_write), .req_funct3(b_req_funct3), .req_addr(b_req_addr),
      .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
      .resp_err(b_resp_err), .mem_address(b_mem_address), .mem_write(b_mem_write),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   assign mem_rdata   = mem[mem_address[5:0]];
   assign b_mem_rdata = 64'h8877665544332211;

   initial forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (mem_write) begin
         mem[mem_address[5:0]] <= mem_wdata;
         wr_cnt = wr_cnt + 1;
      end
      if (b_mem_write) b_wr = b_wr + 1;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act === exp) pass = pass + 1;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic logic [63:0] ref_word(input int w);
      logic [63:0] r;
      for (int b = 0; b < 8; b++) r[8*b +: 8] = ref_mem[w*8 + b];
      return r;
   endfunction

   task automatic set_word(input int w, input logic [63:0] v);
      mem[w] = v;
      for (int b = 0; b < 8; b++) ref_mem[w*8 + b] = v[8*b +: 8];
   endtask

   // Reference: an access is a run of bytes at addr..addr+size-1 in a flat byte memory.
   task automatic model(input bit w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output exp_t e, output int nwr);
      int size, off;
      bit split, ill;
      logic [63:0] v;
      size  = 1 << f3[1:0];
      off   = int'(a[2:0]);
      split = (off + size) > 8;
      ill   = w ? f3[2] : (f3 == 3'b111);
      e.err = ill;
      e.rd  = '0;
      e.lat = (!ill && split) ? 3 : 2;
      nwr   = 0;
      if (!ill) begin
         if (w) begin
            for (int i = 0; i < size; i++) ref_mem[9'(a + 64'(i))] = wd[8*i +: 8];
            nwr = split ? 2 : 1;
         end else begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_mem[9'(a + 64'(i))];
            if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8*size));
            e.rd = v;
         end
      end
   endtask

   task automatic issue(input bit w, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, input bit push, output int hs);
      exp_t e;
      int   n, nwr;
      req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk); #1; n++;
      end
      hs = cyc;
      if (!req_ready) begin
         chk("handshake_timeout", 64'(n), 64'd0);
         req_valid = 1'b0;
         return;
      end
      if (push) begin
         model(w, f3, a, wd, e, nwr);
         e.hs   = cyc;
         exp_wr = exp_wr + nwr;
         q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int bad, idx;
      for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
      @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      bad = -1;
      for (int w = 0; w < 64; w++) if (mem[w] !== ref_word(w) && bad < 0) bad = w;
      idx = (bad < 0) ? 0 : bad;
      chk($sformatf("mem[%0d]", idx), mem[idx], ref_word(idx));
      chk("write_count", 64'(wr_cnt), 64'(exp_wr));
   endtask

   task automatic run_b(input bit w, input logic [2:0] f3, input logic [63:0] a,
                        output logic err, output logic [63:0] rd, output int lat);
      int n, hs;
      b_req_valid = 1'b1; b_req_write = w; b_req_funct3 = f3; b_req_addr = a; b_req_wdata = '1;
      #1;
      n = 0;
      while (!b_req_ready && n < 20) begin @(negedge clk); #1; n++; end
      hs = cyc;
      @(posedge clk); @(negedge clk);
      b_req_valid = 1'b0;
      n = 0;
      while (!b_resp_valid && n < 10) begin @(negedge clk); n++; end
      chk("b_resp_timeout", 64'(b_resp_valid), 64'd1);
      lat = cyc - hs; err = b_resp_err; rd = b_resp_rdata;
   endtask

   // Response checker: every resp_valid must match the oldest outstanding expectation.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (resp_valid) begin
         resp_cnt = resp_cnt + 1;
         chk("resp_expected", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("resp_err", 64'(resp_err), 64'(e.err));
            chk("resp_rdata", resp_rdata, e.rd);
            chk("latency", 64'(cyc - e.hs), 64'(e.lat));
            last_rd = resp_rdata; last_err = resp_err; last_lat = cyc - e.hs;
         end
      end
   end

   initial begin
      int          hs, hs2, rc, lat;
      logic        err;
      logic [63:0] rd;
      bit          w;
      logic [2:0]  f3;
      logic [63:0] a;

      reset = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011; req_addr = '0; req_wdata = '1;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_funct3 = '0; b_req_addr = '0; b_req_wdata = '0;
      for (int i = 0; i < 64; i++) set_word(i, {$urandom, $urandom});
      repeat (3) @(negedge clk);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_mem_write", 64'(mem_write), 64'd0);
      chk("rst_resp_err", 64'(resp_err), 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      reset = 1'b0; req_valid = 1'b0;
      #1 chk("ready_after_reset", 64'(req_ready), 64'd1);
      @(negedge clk);
      chk("no_write_from_reset_handshake", 64'(wr_cnt), 64'd0);

      set_word(2, 64'h8877665544332211);
      issue(0, 3'b011, 64'h10, '0, 1, hs);
      wait_idle();
      chk("ld_rdata", last_rd, 64'h8877665544332211);
      chk("ld_lat", 64'(last_lat), 64'd2);

      set_word(2, 64'h8000_0000_0000_0000);
      issue(0, 3'b000, 64'h17, '0, 1, hs);
      wait_idle();
      chk("lb_rdata", last_rd, 64'hFFFF_FFFF_FFFF_FF80);
      issue(0, 3'b100, 64'h17, '0, 1, hs);
      wait_idle();
      chk("lbu_rdata", last_rd, 64'h80);

      set_word(1, '0); set_word(2, '0);
      issue(1, 3'b010, 64'h0E, 64'hAABBCCDD, 1, hs);
      wait_idle();
      chk("split_sw_mem1", mem[1], 64'hCCDD_0000_0000_0000);
      chk("split_sw_mem2", mem[2], 64'h0000_0000_0000_AABB);
      chk("split_sw_lat", 64'(last_lat), 64'd3);

      rc = wr_cnt;
      issue(1, 3'b100, 64'h20, 64'hFF, 1, hs);
      wait_idle();
      chk("illegal_sb_err", 64'(last_err), 64'd1);
      chk("illegal_sb_rdata", last_rd, 64'd0);
      chk("illegal_sb_nowrite", 64'(wr_cnt - rc), 64'd0);

      set_word(63, 64'h8877665544332211); set_word(0, 64'hAA);
      issue(0, 3'b011, 64'hFFFF_FFFF_FFFF_FFF9, '0, 1, hs);
      chk("wrap_idx0", mem_address, 64'h1FFF_FFFF_FFFF_FFFF);
      @(negedge clk);
      chk("wrap_idx1", mem_address, 64'd0);
      wait_idle();
      chk("wrap_rdata", last_rd, 64'hAA88776655443322);

      issue(1, 3'b010, 64'h30, 64'h12345678, 1, hs);
      issue(0, 3'b010, 64'h30, '0, 1, hs2);
      wait_idle();
      chk("b2b_interval", 64'(hs2 - hs), 64'd3);
      chk("b2b_load", last_rd, 64'h12345678);

      for (int k = 0; k < 300; k++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 511));
         issue(w, f3, a, {$urandom, $urandom}, 1, hs);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();

      set_word(3, '0); set_word(4, '0);
      rc = resp_cnt;
      issue(1, 3'b011, 64'h1C, 64'h1122334455667788, 0, hs);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_wr = exp_wr + 1;
      for (int b = 0; b < 4; b++) ref_mem[16'h1C + b] = 8'(64'h1122334455667788 >> (8*b));
      #1 chk("abort_ready", 64'(req_ready), 64'd1);
      repeat (4) @(negedge clk);
      chk("abort_no_resp", 64'(resp_cnt - rc), 64'd0);
      chk("abort_mem3", mem[3], 64'h5566_7788_0000_0000);
      chk("abort_mem4", mem[4], 64'd0);
      wait_idle();

      run_b(0, 3'b010, 64'h06, err, rd, lat);
      chk("b_lw06_err", 64'(err), 64'd1);
      chk("b_lw06_lat", 64'(lat), 64'd2);
      run_b(0, 3'b010, 64'h04, err, rd, lat);
      chk("b_lw04_err", 64'(err), 64'd0);
      chk("b_lw04_rdata", rd, 64'hFFFF_FFFF_8877_6655);
      run_b(1, 3'b010, 64'h05, err, rd, lat);
      chk("b_sw05_err", 64'(err), 64'd1);
      chk("b_sw05_nowrite", 64'(b_wr), 64'd0);
      chk("b_idle_addr", b_mem_address | b_mem_wdata, 64'd0);

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
